key_event_decoder: RTL and testbench

Sits between the USB keycode export (8-bit HID keycode from the Nios/USB system) and the game logic: ball movers, block_SM Run/start, HEX debug. Filters glitches on the keycode bus, aligns key state to the VGA frame (vs), and drives per-player held-direction levels plus one-cycle press/auto-repeat strobes and a start strobe. Replaces raw keycode compares scattered across consumers.

---
 rtl/key_event_if.sv | 31 +++
 rtl/key_event_decoder.sv | 174 +++++++++++++++++
 tb/tb_key_event_decoder.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_if.sv
// Keycode/frame inputs and decoded key events between the USB
// keycode export and the game logic.
interface key_event_if;
  logic [7:0] keycode;
  logic       frame_clk;
  logic [5:0] held;
  logic       key_strobe;
  logic [2:0] key_id;
  logic       start_pulse;
  logic       frame_tick;

  modport master (
    output keycode,
    output frame_clk,
    input  held,
    input  key_strobe,
    input  key_id,
    input  start_pulse,
    input  frame_tick
  );

  modport slave (
    input  keycode,
    input  frame_clk,
    output held,
    output key_strobe,
    output key_id,
    output start_pulse,
    output frame_tick
  );
endinterface

// File: rtl/key_event_decoder.sv
// Keycode glitch filter, frame-aligned held levels, press/repeat strobes.
// KEY_REPEAT_EN enables auto-repeat of held direction keys.
module key_event_decoder #(
  parameter logic [7:0]  KEY_P0_LEFT   = 8'h04,
  parameter logic [7:0]  KEY_P0_RIGHT  = 8'h07,
  parameter logic [7:0]  KEY_P0_UP     = 8'h1A,
  parameter logic [7:0]  KEY_P1_LEFT   = 8'h50,
  parameter logic [7:0]  KEY_P1_RIGHT  = 8'h4F,
  parameter logic [7:0]  KEY_P1_UP     = 8'h52,
  parameter logic [7:0]  KEY_START     = 8'h28,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY  = 15,
  parameter int unsigned REPEAT_RATE   = 4
) (
  input logic        Clk,
  input logic        Reset,
  key_event_if.slave bus
);

  if (STABLE_CYCLES == 0 || STABLE_CYCLES > 15 ||
      REPEAT_DELAY == 0 || REPEAT_DELAY > 63 ||
      REPEAT_RATE == 0 || REPEAT_RATE > 63) begin : g_cfg_err
    $error("key_event_decoder: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESSED
`ifdef KEY_REPEAT_EN
    , REPEATING
`endif
  } state_e;

  localparam logic [3:0] STB_END = 4'(STABLE_CYCLES - 1);

  logic [7:0] key_q;
  logic [3:0] scnt_q, scnt_d;
  logic [7:0] stable_q, stable_d;
  logic [2:0] fs_q;
  logic       tick_q;
  logic       dec_q;
  logic [7:0] frame_q;
  logic [7:0] prev_q;
  state_e     state_q, state_d;
  logic [5:0] held;
  logic [2:0] id;
  logic       is_dir;
  logic       is_new;
  logic       strobe;

`ifdef KEY_REPEAT_EN
  localparam logic [5:0] DLY_END = 6'(REPEAT_DELAY - 1);
  localparam logic [5:0] RPT_END = 6'(REPEAT_RATE - 1);
  logic [5:0] rcnt_q, rcnt_d;
`endif

  always_comb begin
    scnt_d = scnt_q;
    if (bus.keycode != key_q) begin
      scnt_d = '0;
    end else if (scnt_q != STB_END) begin
      scnt_d = scnt_q + 4'd1;
    end
  end

  // key_q has matched itself STABLE_CYCLES samples in a row
  assign stable_d = (scnt_q == STB_END) ? key_q : stable_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      key_q    <= '0;
      scnt_q   <= '0;
      stable_q <= '0;
      fs_q     <= '0;
      tick_q   <= 1'b0;
      dec_q    <= 1'b0;
      frame_q  <= '0;
      prev_q   <= '0;
    end else begin
      key_q    <= bus.keycode;
      scnt_q   <= scnt_d;
      stable_q <= stable_d;
      fs_q     <= {fs_q[1:0], bus.frame_clk};
      tick_q   <= fs_q[1] & ~fs_q[2];
      dec_q    <= tick_q;
      if (tick_q) begin
        prev_q  <= frame_q;
        frame_q <= stable_q;
      end
    end
  end

  always_comb begin
    held = '0;
    id   = '0;
    unique case (1'b1)
      (frame_q == KEY_P0_LEFT):  begin held[0] = 1'b1; id = 3'd1; end
      (frame_q == KEY_P0_RIGHT): begin held[1] = 1'b1; id = 3'd2; end
      (frame_q == KEY_P0_UP):    begin held[2] = 1'b1; id = 3'd3; end
      (frame_q == KEY_P1_LEFT):  begin held[3] = 1'b1; id = 3'd4; end
      (frame_q == KEY_P1_RIGHT): begin held[4] = 1'b1; id = 3'd5; end
      (frame_q == KEY_P1_UP):    begin held[5] = 1'b1; id = 3'd6; end
      default: ;
    endcase
  end

  assign is_dir = |held;
  assign is_new = frame_q != prev_q;

  always_comb begin
    state_d = state_q;
    strobe  = 1'b0;
`ifdef KEY_REPEAT_EN
    rcnt_d  = rcnt_q;
`endif
    if (dec_q) begin
      if (!is_dir) begin
        state_d = IDLE;
`ifdef KEY_REPEAT_EN
        rcnt_d  = '0;
`endif
      end else if (is_new) begin
        strobe  = 1'b1;
        state_d = PRESSED;
`ifdef KEY_REPEAT_EN
        rcnt_d  = '0;
      end else begin
        unique case (state_q)
          PRESSED: begin
            if (rcnt_q == DLY_END) begin
              strobe  = 1'b1;
              rcnt_d  = '0;
              state_d = REPEATING;
            end else begin
              rcnt_d = rcnt_q + 6'd1;
            end
          end
          REPEATING: begin
            if (rcnt_q == RPT_END) begin
              strobe = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + 6'd1;
            end
          end
          default: ;
        endcase
`endif
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
`ifdef KEY_REPEAT_EN
      rcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef KEY_REPEAT_EN
      rcnt_q  <= rcnt_d;
`endif
    end
  end

  assign bus.held        = held;
  assign bus.key_strobe  = strobe;
  assign bus.key_id      = strobe ? id : 3'd0;
  assign bus.start_pulse = dec_q & (frame_q == KEY_START) &
                           (prev_q != KEY_START);
  assign bus.frame_tick  = tick_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: random keycodes and frame periods
// checked every cycle against a frame-level reference model.
module tb_key_event_decoder;

  localparam int S = 4;
  localparam int D = 15;
  localparam int R = 4;

  logic Clk = 1'b0;
  logic Reset;
  key_event_if bus ();

  key_event_decoder dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_run_val;
  int         m_run_len;
  logic [7:0] m_stable;
  logic [7:0] m_frame;
  logic [7:0] m_prev;
  logic [2:0] m_fh;
  logic       m_tick;
  logic       m_dec;
  int         m_n;

  int fcnt;
  int fper;
  int n_strobe;
  int n_start;
  int n_tick;
  logic [2:0] first_id;
  logic [2:0] last_id;

  function automatic int dir_id(input logic [7:0] c);
    case (c)
      8'h04: return 1;
      8'h07: return 2;
      8'h1A: return 3;
      8'h50: return 4;
      8'h4F: return 5;
      8'h52: return 6;
      default: return 0;
    endcase
  endfunction

  // k = frames elapsed since the press frame
  function automatic bit sched(input int k);
    if (k == 0) return 1'b1;
`ifdef KEY_REPEAT_EN
    if (k >= D && ((k - D) % R) == 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run_val = 8'h00;
    m_run_len = 1;
    m_stable  = 8'h00;
    m_frame   = 8'h00;
    m_prev    = 8'h00;
    m_fh      = 3'b000;
    m_tick    = 1'b0;
    m_dec     = 1'b0;
    m_n       = 0;
  endtask

  task automatic model_edge();
    logic [7:0] ns;
    logic       nt;
    if (m_dec && dir_id(m_frame) != 0)
      m_n = (m_frame != m_prev) ? 0 : m_n + 1;
    ns = (m_run_len >= S) ? m_run_val : m_stable;
    nt = m_fh[1] & ~m_fh[2];
    m_dec = m_tick;
    if (m_tick) begin
      m_prev  = m_frame;
      m_frame = m_stable;
    end
    m_tick   = nt;
    m_stable = ns;
    m_fh     = {m_fh[1:0], bus.frame_clk};
    if (bus.keycode == m_run_val) begin
      m_run_len++;
    end else begin
      m_run_val = bus.keycode;
      m_run_len = 1;
    end
  endtask

  task automatic check_outputs();
    int         id;
    logic [5:0] e_held;
    logic       e_str;
    logic [2:0] e_id;
    logic       e_start;
    id = dir_id(m_frame);
    e_held = (id != 0) ? 6'(1 << (id - 1)) : 6'd0;
    e_str = m_dec && id != 0 &&
            ((m_frame != m_prev) || sched(m_n + 1));
    e_id = e_str ? 3'(id) : 3'd0;
    e_start = m_dec && m_frame == 8'h28 && m_prev != 8'h28;
    chk("held", 32'(bus.held), 32'(e_held));
    chk("key_strobe", 32'(bus.key_strobe), 32'(e_str));
    chk("key_id", 32'(bus.key_id), 32'(e_id));
    chk("start_pulse", 32'(bus.start_pulse), 32'(e_start));
    chk("frame_tick", 32'(bus.frame_tick), 32'(m_tick));
  endtask

  task automatic cyc();
    @(posedge Clk);
    if (Reset) model_edge();
    else model_reset();
    @(negedge Clk);
    check_outputs();
    if (bus.key_strobe) begin
      n_strobe++;
      last_id = bus.key_id;
      if (first_id == 3'd0) first_id = bus.key_id;
    end
    if (bus.start_pulse) n_start++;
    if (bus.frame_tick) n_tick++;
    fcnt++;
    if (fcnt >= fper) begin
      fcnt = 0;
      fper = $urandom_range(10, 18);
    end
    bus.frame_clk = (fcnt < 3) ? 1'b0 : 1'b1;
  endtask

  task automatic frames(input int n);
    int t;
    int guard;
    t = 0;
    guard = 0;
    while (t < n && guard < n * 40) begin
      cyc();
      guard++;
      if (m_tick) t++;
    end
    if (t < n) chk("frame_timeout", 32'(t), 32'(n));
  endtask

  task automatic clr_counts();
    n_strobe = 0;
    n_start  = 0;
    n_tick   = 0;
    first_id = 3'd0;
    last_id  = 3'd0;
  endtask

  initial begin
    logic [7:0] pool [9];
    logic [7:0] base;
    int         hold;
    int         guard;
    bit         found;
    pool = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h50,
             8'h4F, 8'h52, 8'h28, 8'h33};
    Reset = 1'b0;
    bus.keycode = 8'h00;
    bus.frame_clk = 1'b1;
    fcnt = 5;
    fper = 12;
    clr_counts();
    model_reset();

    repeat (4) cyc();
    Reset = 1'b1;
    frames(3);

    // glitch 00->07->00 then 07 stable
    clr_counts();
    bus.keycode = 8'h07;
    cyc();
    bus.keycode = 8'h00;
    cyc();
    bus.keycode = 8'h07;
    frames(3);
    chk("glitch_strobes", 32'(n_strobe), 32'd1);
    chk("glitch_id", 32'(first_id), 32'd2);
    chk("glitch_held", 32'(bus.held), 32'h02);

    bus.keycode = 8'h00;
    frames(3);

    // long hold of player 0 up
    clr_counts();
    bus.keycode = 8'h1A;
    frames(32);
`ifdef KEY_REPEAT_EN
    chk("hold_strobes", 32'(n_strobe), 32'd5);
`else
    chk("hold_strobes", 32'(n_strobe), 32'd1);
`endif
    chk("hold_id", 32'(last_id), 32'd3);

    // direct switch between player 1 directions
    bus.keycode = 8'h50;
    frames(5);
    clr_counts();
    bus.keycode = 8'h4F;
    frames(3);
    chk("switch_strobes", 32'(n_strobe), 32'd1);
    chk("switch_id", 32'(first_id), 32'd5);
    chk("switch_held", 32'(bus.held), 32'h10);
    frames(20);

    // start key held
    bus.keycode = 8'h00;
    frames(2);
    clr_counts();
    bus.keycode = 8'h28;
    frames(40);
    chk("start_once", 32'(n_start), 32'd1);
    chk("start_no_strobe", 32'(n_strobe), 32'd0);
    chk("start_held", 32'(bus.held), 32'h00);

    // keycode changes during the frame_tick cycle
    bus.keycode = 8'h04;
    frames(3);
    guard = 0;
    while (!m_tick && guard < 40) begin
      cyc();
      guard++;
    end
    bus.keycode = 8'h07;
    cyc();
    chk("tick_edge_old", 32'(bus.held), 32'h01);
    frames(2);
    chk("tick_edge_new", 32'(bus.held), 32'h02);

    // random keys with occasional one-cycle glitches
    for (int i = 0; i < 40; i++) begin
      base = pool[$urandom_range(0, 8)];
      hold = $urandom_range(1, 60);
      for (int j = 0; j < hold; j++) begin
        bus.keycode = ($urandom_range(0, 15) == 0) ?
                      8'($urandom) : base;
        cyc();
      end
    end

    // reset during a long hold
    bus.keycode = 8'h00;
    frames(2);
    bus.keycode = 8'h04;
    frames(30);
    #3;
    Reset = 1'b0;
    model_reset();
    #1;
    chk("rst_held", 32'(bus.held), 32'h00);
    chk("rst_strobe", 32'(bus.key_strobe), 32'd0);
    chk("rst_id", 32'(bus.key_id), 32'd0);
    chk("rst_start", 32'(bus.start_pulse), 32'd0);
    chk("rst_tick", 32'(bus.frame_tick), 32'd0);
    repeat (3) cyc();
    guard = 0;
    while (fcnt != 4 && guard < 40) begin
      cyc();
      guard++;
    end
    Reset = 1'b1;
    clr_counts();
    found = 1'b0;
    guard = 0;
    while (!found && guard < 100) begin
      cyc();
      guard++;
      if (n_strobe != 0) found = 1'b1;
    end
    chk("rst_press_found", 32'(found), 32'd1);
    chk("rst_press_ticks", 32'(n_tick), 32'd2);
    chk("rst_press_id", 32'(first_id), 32'd1);
    frames(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
